// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI SRAM target and master: opcodes and the
// protocol state encoding.
package spi_sram_pkg;

   localparam logic [7:0] WRITE_CMD     = 8'h02;
   localparam logic [7:0] READ_CMD      = 8'h03;
   localparam logic [7:0] FAST_READ_CMD = 8'h0B;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      RDATA,
      WDATA,
      IGNORE
   } spi_state_e;

   function automatic logic is_known_cmd(input logic [7:0] op);
      return (op == WRITE_CMD) || (op == READ_CMD) || (op == FAST_READ_CMD);
   endfunction

endpackage

// File: rtl/spi_sram_pin_sync.sv
// Pin synchronizer with edge pulses.
//   clk_i    system clock
//   rst_n_i  asynchronous active-low reset
//   pin_i    asynchronous input pin
//   level_o  synchronized level (RESET_VAL during reset)
//   rise_o   one-clk pulse on a synchronized 0->1 transition
//   fall_o   one-clk pulse on a synchronized 1->0 transition
module spi_pin_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = level_o & ~prev_q;
   assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_sram_target.sv
// SPI mode-0 SRAM responder (02 write / 03 read / 0B fast read) bridging
// onto a byte-wide ready-handshake memory port.
//   clk, rst_n           system clock, async active-low reset
//   spi_sck/cs_n/mosi    SPI pins (asynchronous, oversampled on clk)
//   spi_miso/_oe         serial data out and pad enable
//   mem_*                byte memory request port, held until mem_rdy
//   busy                 synchronized chip select asserted
//   err_underrun/err_clr sticky underrun flag and its clear
//
// state  | meaning
// IDLE   | chip select high, nothing in progress
// CMD    | shifting in the 8-bit opcode
// ADDR   | shifting in the 24-bit address
// DUMMY  | fast-read turnaround bits
// RDATA  | serving read bytes on MISO
// WDATA  | receiving write bytes
// IGNORE | unknown opcode, wait for chip select high
module spi_sram_target
   import spi_sram_pkg::*;
#(
   parameter int ADDR_BITS   = 24,
   parameter int SYNC_STAGES = 2,
   parameter int DUMMY_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 spi_sck,
   input  logic                 spi_cs_n,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic                 spi_miso_oe,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_en,
   output logic                 mem_wr,
   output logic [7:0]           mem_wdata,
   input  logic                 mem_rdy,
   input  logic [7:0]           mem_rdata,
   output logic                 busy,
   output logic                 err_underrun,
   input  logic                 err_clr
);

   localparam logic [5:0] DUMMY_LAST = 6'(DUMMY_BITS - 1);

   logic sck_lvl, sck_rise, sck_fall;
   logic cs_n_s, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic mosi_s;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .pin_i   (spi_sck),
      .level_o (sck_lvl),
      .rise_o  (sck_rise),
      .fall_o  (sck_fall)
   );

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .pin_i   (spi_cs_n),
      .level_o (cs_n_s),
      .rise_o  (cs_rise),
      .fall_o  (cs_fall)
   );

   logic unused_sync;
   assign unused_sync = &{1'b0, sck_lvl, cs_rise, cs_fall};

   // Same stage count as SCK so MOSI is stable in the sck_rise clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mosi_sync_q <= '0;
      else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
   end
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   spi_state_e           state_q, state_d;
   logic [5:0]           bit_cnt_q, bit_cnt_d;
   logic [7:0]           cmd_q, cmd_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [7:0]           rx_q, rx_d;
   logic [7:0]           tx_q, tx_d;
   logic [7:0]           buf_q, buf_d;
   logic                 buf_vld_q, buf_vld_d;
   logic                 fetch_pend_q, fetch_pend_d;
   logic                 miso_q, miso_d;
   logic                 oe_q, oe_d;
   logic                 mem_en_q, mem_en_d;
   logic                 mem_wr_q, mem_wr_d;
   logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]           mem_wdata_q, mem_wdata_d;
   logic                 err_q, err_d;

   logic       mem_done;
   logic       err_set;
   logic       fetch_new;
   logic [7:0] rx_shift;

   assign mem_done = mem_en_q & mem_rdy;
   assign rx_shift = {rx_q[6:0], mosi_s};

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      cmd_d        = cmd_q;
      addr_d       = addr_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      buf_d        = buf_q;
      buf_vld_d    = buf_vld_q;
      fetch_pend_d = fetch_pend_q;
      miso_d       = miso_q;
      oe_d         = oe_q;
      mem_en_d     = mem_en_q;
      mem_wr_d     = mem_wr_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      err_set      = 1'b0;
      fetch_new    = 1'b0;

      // A completing access always retires, even after chip select rose.
      if (mem_done) begin
         mem_en_d = 1'b0;
         if (!mem_wr_q && state_q == RDATA) begin
            buf_d     = mem_rdata;
            buf_vld_d = 1'b1;
         end
      end

      if (cs_n_s) begin
         state_d      = IDLE;
         bit_cnt_d    = '0;
         rx_d         = '0;
         tx_d         = '0;
         buf_vld_d    = 1'b0;
         fetch_pend_d = 1'b0;
         miso_d       = 1'b0;
         oe_d         = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d   = CMD;
               bit_cnt_d = '0;
            end
            CMD: if (sck_rise) begin
               rx_d      = rx_shift;
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd7) begin
                  bit_cnt_d = '0;
                  cmd_d     = rx_shift;
                  state_d   = is_known_cmd(rx_shift) ? ADDR : IGNORE;
               end
            end
            ADDR: if (sck_rise) begin
               // Upper bits fall off the top, leaving the low ADDR_BITS.
               addr_d    = {addr_q[ADDR_BITS-2:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd23) begin
                  bit_cnt_d = '0;
                  if (cmd_q == WRITE_CMD) begin
                     state_d = WDATA;
                  end else if (cmd_q == FAST_READ_CMD && DUMMY_BITS != 0) begin
                     state_d = DUMMY;
                  end else begin
                     state_d   = RDATA;
                     fetch_new = 1'b1;
                  end
               end
            end
            DUMMY: if (sck_rise) begin
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == DUMMY_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = RDATA;
                  fetch_new = 1'b1;
               end
            end
            WDATA: if (sck_rise) begin
               rx_d      = rx_shift;
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd7) begin
                  bit_cnt_d = '0;
                  if (mem_en_q && !mem_done) begin
                     err_set = 1'b1;
                  end else begin
                     mem_en_d    = 1'b1;
                     mem_wr_d    = 1'b1;
                     mem_addr_d  = addr_q;
                     mem_wdata_d = rx_shift;
                     addr_d      = addr_q + 1'b1;
                  end
               end
            end
            RDATA: if (sck_fall) begin
               oe_d      = 1'b1;
               bit_cnt_d = (bit_cnt_q == 6'd7) ? 6'd0 : bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd0) begin
                  // Bit 7 due: take the buffer, or the read completing right now.
                  if (buf_vld_q) begin
                     miso_d    = buf_q[7];
                     tx_d      = {buf_q[6:0], 1'b0};
                     buf_vld_d = 1'b0;
                     fetch_new = 1'b1;
                  end else if (mem_done && !mem_wr_q) begin
                     miso_d    = mem_rdata[7];
                     tx_d      = {mem_rdata[6:0], 1'b0};
                     buf_vld_d = 1'b0;
                     fetch_new = 1'b1;
                  end else begin
                     miso_d  = 1'b0;
                     tx_d    = '0;
                     err_set = 1'b1;
                  end
               end else begin
                  miso_d = tx_q[7];
                  tx_d   = {tx_q[6:0], 1'b0};
               end
            end
            IGNORE: ;
            default: state_d = IDLE;
         endcase

         // Read fetches wait for the port to free up; only one access is ever open.
         if (fetch_new || fetch_pend_q) begin
            if (!mem_en_q || mem_done) begin
               mem_en_d     = 1'b1;
               mem_wr_d     = 1'b0;
               mem_addr_d   = addr_d;
               addr_d       = addr_d + 1'b1;
               fetch_pend_d = 1'b0;
            end else begin
               fetch_pend_d = 1'b1;
            end
         end
      end

      err_d = err_q;
      if (err_clr) err_d = 1'b0;
      if (err_set) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         cmd_q        <= '0;
         addr_q       <= '0;
         rx_q         <= '0;
         tx_q         <= '0;
         buf_q        <= '0;
         buf_vld_q    <= 1'b0;
         fetch_pend_q <= 1'b0;
         miso_q       <= 1'b0;
         oe_q         <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         cmd_q        <= cmd_d;
         addr_q       <= addr_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         buf_q        <= buf_d;
         buf_vld_q    <= buf_vld_d;
         fetch_pend_q <= fetch_pend_d;
         miso_q       <= miso_d;
         oe_q         <= oe_d;
         mem_en_q     <= mem_en_d;
         mem_wr_q     <= mem_wr_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         err_q        <= err_d;
      end
   end

   assign spi_miso     = miso_q;
   assign spi_miso_oe  = oe_q;
   assign mem_addr     = mem_addr_q;
   assign mem_en       = mem_en_q;
   assign mem_wr       = mem_wr_q;
   assign mem_wdata    = mem_wdata_q;
   assign busy         = ~cs_n_s;
   assign err_underrun = err_q;

endmodule
